// File: rtl/risc16_pkg.sv
// risc16_pkg: shared types for the 16-bit RISC core.
// Holds the machine word and the fetch queue slot layout.
package risc16_pkg;

   typedef logic [15:0] word_t;

   typedef struct packed {
      logic  alloc;
      logic  filled;
      word_t pc;
      word_t instr;
   } fetch_slot_t;

   localparam int unsigned FETCH_DEPTH = 2;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// fetch_queue: 2-slot in-order queue of fetch slots.
// Slots are allocated at issue, filled by responses, popped by IF/ID.
module fetch_queue
   import risc16_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        alloc_i,
   input  word_t       alloc_pc_i,
   input  logic        fill_i,
   input  word_t       fill_instr_i,
   input  logic        pop_i,
   output fetch_slot_t head_o,
   output logic [1:0]  count_o,
   output logic [1:0]  unfilled_o
);

   fetch_slot_t [1:0] slot_q, slot_d;
   logic              head_q, head_d;
   logic              tail_q, tail_d;
   logic              fill_hit;
   logic              fill_sel;
   logic              unf0, unf1;

   assign unf0 = slot_q[0].alloc & ~slot_q[0].filled;
   assign unf1 = slot_q[1].alloc & ~slot_q[1].filled;

   assign head_o     = slot_q[head_q];
   assign count_o    = {1'b0, slot_q[0].alloc} + {1'b0, slot_q[1].alloc};
   assign unfilled_o = {1'b0, unf0} + {1'b0, unf1};

   // Locate the oldest allocated-but-unfilled slot (head first).
   always_comb begin
      fill_hit = 1'b0;
      fill_sel = head_q;
      if (slot_q[head_q].alloc && !slot_q[head_q].filled) begin
         fill_hit = 1'b1;
         fill_sel = head_q;
      end else if (slot_q[~head_q].alloc && !slot_q[~head_q].filled) begin
         fill_hit = 1'b1;
         fill_sel = ~head_q;
      end
   end

   // Next-state: flush wins; otherwise fill, pop, then allocate.
   always_comb begin
      slot_d = slot_q;
      head_d = head_q;
      tail_d = tail_q;
      if (flush_i) begin
         slot_d = '0;
         head_d = 1'b0;
         tail_d = 1'b0;
      end else begin
         if (fill_i && fill_hit) begin
            slot_d[fill_sel].filled = 1'b1;
            slot_d[fill_sel].instr  = fill_instr_i;
         end
         if (pop_i) begin
            slot_d[head_q] = '0;
            head_d         = ~head_q;
         end
         // When full, tail aliases the popped head slot; alloc reuses it.
         if (alloc_i) begin
            slot_d[tail_q].alloc  = 1'b1;
            slot_d[tail_q].filled = 1'b0;
            slot_d[tail_q].pc     = alloc_pc_i;
            slot_d[tail_q].instr  = '0;
            tail_d                = ~tail_q;
         end
      end
   end

   // Slot and pointer registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot_q <= '0;
         head_q <= 1'b0;
         tail_q <= 1'b0;
      end else begin
         slot_q <= slot_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage feeding IF/ID.
// Owns the fetch PC, request handshake, discard count and error flag.
module if_fetch_unit
   import risc16_pkg::*;
#(
   parameter word_t       RESET_PC = 16'h0000,
   parameter int unsigned DEPTH    = FETCH_DEPTH
) (
   input  logic  clk,
   input  logic  rst,
   output logic  imem_req_valid,
   input  logic  imem_req_ready,
   output word_t imem_req_addr,
   input  logic  imem_rsp_valid,
   input  word_t imem_rsp_data,
   input  logic  stall,
   input  logic  redirect_valid,
   input  word_t redirect_pc,
   output logic  fetch_valid,
   output word_t fetch_instr,
   output word_t fetch_pc,
   output logic  proto_err
);

   localparam logic [2:0] CAP = 3'(DEPTH);

   word_t       pc_q, pc_d;
   logic [1:0]  drop_q, drop_d;
   logic        perr_q, perr_d;

   fetch_slot_t head;
   logic [1:0]  q_count;
   logic [1:0]  q_unfilled;
   logic [1:0]  pending;
   logic [2:0]  occupancy;
   logic        pop;
   logic        issue;
   logic        rsp_drop;
   logic        rsp_fill;
   logic        rsp_orphan;

   assign fetch_valid = head.alloc & head.filled;
   assign fetch_instr = head.instr;
   assign fetch_pc    = head.pc;
   assign proto_err   = perr_q;

   // Pop feeds the request decision so a full queue can still
   // issue in the same cycle it hands an instruction to IF/ID.
   assign pop       = fetch_valid & ~stall & ~redirect_valid;
   assign occupancy = {1'b0, q_count} + {1'b0, drop_q} - {2'b00, pop};

   assign imem_req_valid = ~rst & ~redirect_valid & (occupancy < CAP);
   assign imem_req_addr  = pc_q;
   assign issue          = imem_req_valid & imem_req_ready;

   assign rsp_drop   = imem_rsp_valid & (drop_q != 2'd0);
   assign rsp_fill   = imem_rsp_valid & (drop_q == 2'd0) & (q_unfilled != 2'd0);
   assign rsp_orphan = imem_rsp_valid & (drop_q == 2'd0) & (q_unfilled == 2'd0);

   // Responses still owed to slots that a redirect throws away.
   assign pending = q_unfilled + drop_q;

   fetch_queue u_queue (
      .clk_i        (clk),
      .rst_i        (rst),
      .flush_i      (redirect_valid),
      .alloc_i      (issue),
      .alloc_pc_i   (pc_q),
      .fill_i       (rsp_fill),
      .fill_instr_i (imem_rsp_data),
      .pop_i        (pop),
      .head_o       (head),
      .count_o      (q_count),
      .unfilled_o   (q_unfilled)
   );

   // PC, discard count and sticky error next-state.
   always_comb begin
      pc_d   = pc_q;
      drop_d = drop_q;
      perr_d = perr_q | rsp_orphan;
      if (redirect_valid) begin
         pc_d   = redirect_pc;
         drop_d = pending - {1'b0, imem_rsp_valid & (pending != 2'd0)};
      end else begin
         if (issue) begin
            pc_d = pc_q + 16'd1;
         end
         if (rsp_drop) begin
            drop_d = drop_q - 2'd1;
         end
      end
   end

   // Stage state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         drop_q <= 2'd0;
         perr_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
         perr_q <= perr_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized bench with a queue-level reference model.
// A second instance with RESET_PC=16'hFFFE pins PC wrap with literals.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_valid, req_ready;
   logic [15:0] req_addr;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        stall, redir;
   logic [15:0] redir_pc;
   logic        f_valid;
   logic [15:0] f_instr, f_pc;
   logic        perr;

   logic        req2_valid, ready2;
   logic [15:0] req2_addr;
   logic        rsp2_valid;
   logic [15:0] rsp2_data;
   logic        stall2, redir2;
   logic [15:0] redir_pc2;
   logic        f2_valid;
   logic [15:0] f2_instr, f2_pc;
   logic        perr2;

   always #5 clk = ~clk;

   if_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(req_valid), .imem_req_ready(req_ready),
      .imem_req_addr(req_addr),
      .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
      .stall(stall), .redirect_valid(redir), .redirect_pc(redir_pc),
      .fetch_valid(f_valid), .fetch_instr(f_instr), .fetch_pc(f_pc),
      .proto_err(perr)
   );

   if_fetch_unit #(.RESET_PC(16'hFFFE), .DEPTH(2)) dut2 (
      .clk(clk), .rst(rst),
      .imem_req_valid(req2_valid), .imem_req_ready(ready2),
      .imem_req_addr(req2_addr),
      .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
      .stall(stall2), .redirect_valid(redir2), .redirect_pc(redir_pc2),
      .fetch_valid(f2_valid), .fetch_instr(f2_instr), .fetch_pc(f2_pc),
      .proto_err(perr2)
   );

   typedef struct {
      logic [15:0] pc;
      bit          keep;
   } inflight_t;

   typedef struct {
      logic [15:0] addr;
      int          due;
   } mreq_t;

   // Reference model: issued requests awaiting data, then delivered PCs.
   inflight_t   infl[$];
   logic [15:0] rdyq[$];
   logic [15:0] m_req_pc;
   bit          m_perr;

   mreq_t       mem[$];
   int          last_due;
   int          cyc;
   int          since_rst;

   int          p_ready, p_stall, p_redir;
   int          lat_min, lat_max;
   bit          spurious;
   bit          redir_fix;
   logic [15:0] redir_fix_pc;
   bit          rst_req;

   bit          prev_hold;
   logic [15:0] prev_addr;

   bit          pend2;
   logic [15:0] pend2_addr;
   int          idx2;
   logic [15:0] lit_pc [4];
   logic [15:0] lit_in [4];

   int          n_pass;
   int          n_total;

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)",
                    name, act, exp, cyc);
   endtask

   task automatic check_and_update();
      bit        e_pop, e_rv;
      inflight_t ent;
      int        d;
      if (rst) begin
         chk("rst_req_valid", {15'd0, req_valid}, 16'd0);
         chk("rst_req_addr", req_addr, 16'h0000);
         chk("rst_fetch_valid", {15'd0, f_valid}, 16'd0);
         chk("rst_fetch_instr", f_instr, 16'h0000);
         chk("rst_fetch_pc", f_pc, 16'h0000);
         chk("rst_proto_err", {15'd0, perr}, 16'd0);
         chk("rst2_req_addr", req2_addr, 16'hFFFE);
         chk("rst2_req_valid", {15'd0, req2_valid}, 16'd0);
         infl.delete();
         rdyq.delete();
         mem.delete();
         m_req_pc  = 16'h0000;
         m_perr    = 1'b0;
         prev_hold = 1'b0;
         pend2     = 1'b0;
         return;
      end
      e_pop = (rdyq.size() > 0) && !stall && !redir;
      e_rv  = !redir &&
              (infl.size() + rdyq.size() - (e_pop ? 1 : 0) < 2);
      chk("req_valid", {15'd0, req_valid}, {15'd0, e_rv});
      if (e_rv) chk("req_addr", req_addr, m_req_pc);
      chk("fetch_valid", {15'd0, f_valid}, {15'd0, rdyq.size() > 0});
      if (rdyq.size() > 0) begin
         chk("fetch_pc", f_pc, rdyq[0]);
         chk("fetch_instr", f_instr, rdyq[0] ^ 16'hA5A5);
      end
      chk("proto_err", {15'd0, perr}, {15'd0, m_perr});
      if (prev_hold && !redir) begin
         chk("hold_valid", {15'd0, req_valid}, 16'd1);
         chk("hold_addr", req_addr, prev_addr);
      end
      prev_hold = req_valid && !req_ready;
      prev_addr = req_addr;

      if (e_pop) void'(rdyq.pop_front());
      if (rsp_valid) begin
         if (infl.size() == 0) m_perr = 1'b1;
         else begin
            ent = infl.pop_front();
            if (ent.keep) rdyq.push_back(ent.pc);
         end
      end
      if (redir) begin
         rdyq.delete();
         foreach (infl[i]) infl[i].keep = 1'b0;
         m_req_pc = redir_pc;
      end else if (e_rv && req_ready) begin
         infl.push_back('{m_req_pc, 1'b1});
         m_req_pc = m_req_pc + 16'd1;
      end

      if (req_valid && req_ready) begin
         d = cyc + int'($urandom_range(lat_max, lat_min));
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         mem.push_back('{req_addr, d});
      end

      chk("dut2_proto_err", {15'd0, perr2}, 16'd0);
      if (f2_valid && idx2 < 4) begin
         if (idx2 == 0) chk("dut2_first_latency", 16'(since_rst), 16'd2);
         chk("dut2_pc", f2_pc, lit_pc[idx2]);
         chk("dut2_instr", f2_instr, lit_in[idx2]);
         idx2++;
      end
      pend2      = req2_valid;
      pend2_addr = req2_addr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      rst = rst_req;
      if (rst) since_rst = -1;
      else since_rst++;
      req_ready = (int'($urandom_range(99)) < p_ready);
      stall     = (int'($urandom_range(99)) < p_stall);
      redir     = (int'($urandom_range(99)) < p_redir);
      redir_pc  = 16'($urandom);
      if (redir_fix) begin
         redir     = 1'b1;
         redir_pc  = redir_fix_pc;
         redir_fix = 1'b0;
      end
      if (mem.size() > 0 && mem[0].due <= cyc) begin
         rsp_valid = 1'b1;
         rsp_data  = mem[0].addr ^ 16'hA5A5;
         void'(mem.pop_front());
      end else if (spurious) begin
         rsp_valid = 1'b1;
         rsp_data  = 16'h1234;
         spurious  = 1'b0;
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = 16'h0000;
      end
      rsp2_valid = pend2 && !rst;
      rsp2_data  = pend2_addr ^ 16'hA5A5;
      @(negedge clk);
      check_and_update();
   endtask

   logic [15:0] rec_pc, rec_in;
   int          guard;

   initial begin
      n_pass = 0; n_total = 0;
      cyc = 0; since_rst = -1; last_due = 0;
      p_ready = 100; p_stall = 0; p_redir = 0;
      lat_min = 1; lat_max = 1;
      spurious = 1'b0; redir_fix = 1'b0; redir_fix_pc = 16'h0000;
      rst_req = 1'b1; prev_hold = 1'b0; prev_addr = 16'h0000;
      pend2 = 1'b0; pend2_addr = 16'h0000; idx2 = 0;
      m_req_pc = 16'h0000; m_perr = 1'b0;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 16'h0000;
      stall = 1'b0; redir = 1'b0; redir_pc = 16'h0000;
      ready2 = 1'b1; rsp2_valid = 1'b0; rsp2_data = 16'h0000;
      stall2 = 1'b0; redir2 = 1'b0; redir_pc2 = 16'h0000;
      lit_pc[0] = 16'hFFFE; lit_in[0] = 16'h5A5B;
      lit_pc[1] = 16'hFFFF; lit_in[1] = 16'h5A5A;
      lit_pc[2] = 16'h0000; lit_in[2] = 16'hA5A5;
      lit_pc[3] = 16'h0001; lit_in[3] = 16'hA5A4;

      repeat (3) step();
      rst_req = 1'b0;

      // Back-to-back fetch from reset with a 1-cycle memory.
      step();
      chk("first_req_addr", req_addr, 16'h0000);
      step();
      chk("no_data_yet", {15'd0, f_valid}, 16'd0);
      step();
      chk("lit_valid_c2", {15'd0, f_valid}, 16'd1);
      chk("lit_pc_c2", f_pc, 16'h0000);
      chk("lit_instr_c2", f_instr, 16'hA5A5);
      step();
      chk("lit_pc_c3", f_pc, 16'h0001);
      repeat (12) step();

      // Full queue held by stall for 3 cycles.
      p_stall = 100;
      step();
      rec_pc = f_pc;
      rec_in = f_instr;
      repeat (2) begin
         step();
         chk("stall_pc", f_pc, rec_pc);
         chk("stall_instr", f_instr, rec_in);
         chk("stall_req_valid", {15'd0, req_valid}, 16'd0);
      end
      p_stall = 0;
      repeat (6) step();

      // Two requests in flight, then redirect to 16'h0040.
      lat_min = 3; lat_max = 3;
      guard = 0;
      while (!(infl.size() == 2) && guard < 20) begin
         step();
         guard++;
      end
      chk("two_inflight", 16'(infl.size()), 16'd2);
      redir_fix = 1'b1;
      redir_fix_pc = 16'h0040;
      step();
      guard = 0;
      do begin
         step();
         guard++;
      end while (!f_valid && guard < 20);
      chk("redirect_pc", f_pc, 16'h0040);
      chk("redirect_instr", f_instr, 16'hA5E5);
      lat_min = 1; lat_max = 1;
      repeat (6) step();

      // Memory not ready for 4 cycles.
      p_ready = 0;
      step();
      rec_pc = req_addr;
      repeat (3) begin
         step();
         chk("notready_valid", {15'd0, req_valid}, 16'd1);
         chk("notready_addr", req_addr, rec_pc);
      end
      p_ready = 100;
      repeat (6) step();

      // Randomized traffic.
      p_ready = 70; p_stall = 25; p_redir = 5;
      lat_min = 1; lat_max = 3;
      repeat (3000) step();

      // Quiesce, then inject an unsolicited response.
      p_ready = 0; p_stall = 0; p_redir = 0;
      guard = 0;
      while ((infl.size() != 0 || rdyq.size() != 0 || mem.size() != 0)
             && guard < 30) begin
         step();
         guard++;
      end
      chk("quiesced", 16'(infl.size() + rdyq.size()), 16'd0);
      spurious = 1'b1;
      step();
      step();
      chk("proto_err_set", {15'd0, perr}, 16'd1);
      chk("proto_no_fetch", {15'd0, f_valid}, 16'd0);
      repeat (3) step();
      chk("proto_err_sticky", {15'd0, perr}, 16'd1);

      // Reset clears the sticky error.
      rst_req = 1'b1;
      step();
      step();
      rst_req = 1'b0;
      p_ready = 70; p_stall = 25; p_redir = 5;
      repeat (500) step();

      // Mid-operation reset with memory quiesced.
      rst_req = 1'b1;
      step();
      rst_req = 1'b0;
      repeat (300) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage of the 16-bit pipelined RISC core; sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues word-addressed requests to instruction memory over a valid/ready request channel, with in-order responses. Returned instructions are buffered in a 2-entry queue and presented with their PC to IF/ID. It obeys the hazard unit's stall and pc_control's redirect/flush.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address after reset
- DEPTH, 2, total request/instruction slots; fixed at 2, other values unsupported

Ports:
- clk  input  1  core clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  16  word address of request
- imem_rsp_valid  input  1  response valid; in-order, no backpressure
- imem_rsp_data  input  16  instruction word
- stall  input  1  hazard unit hold; IF/ID does not take an instruction this cycle
- redirect_valid  input  1  branch/jump taken; flush fetch stage
- redirect_pc  input  16  new fetch address
- fetch_valid  output  1  fetch_instr/fetch_pc valid for IF/ID
- fetch_instr  output  16  instruction at queue head
- fetch_pc  output  16  PC of that instruction
- proto_err  output  1  sticky: response received with nothing outstanding

## Operation
- State: pc_q, 2-slot circular queue (per slot: alloc, filled, pc, instr), head/tail pointers, drop_cnt (0..2), proto_err.
- pop = fetch_valid & ~stall & ~redirect_valid; frees the head slot at the clock edge.
- count = allocated slots; drop_cnt = issued requests whose responses must be discarded.
- imem_req_valid = ~redirect_valid & (count − pop + drop_cnt < 2); imem_req_addr = pc_q.
- Issue (valid & ready): allocate tail slot with pc = pc_q; pc_q <= pc_q + 1, modulo 2^16 (16'hFFFF → 16'h0000).
- Response: if drop_cnt > 0, discard and decrement drop_cnt; else if an allocated unfilled slot exists, fill the oldest one; otherwise discard and set proto_err.
- fetch_valid = head slot allocated & filled; fetch_instr and fetch_pc are taken from the head slot.
- Redirect (priority over pop, issue, and stall):
  - all slots are cleared;
  - drop_cnt <= (allocated unfilled slots + drop_cnt) − (1 if a response arrives this cycle);
  - pc_q <= redirect_pc;
  - no request is issued that cycle.
- Stall: queue contents and head are held; issue continues while capacity allows.

## Timing
- Reset values:
  - imem_req_valid 0 while rst high; imem_req_addr = RESET_PC;
  - fetch_valid 0, fetch_instr 16'h0000, fetch_pc 16'h0000;
  - proto_err 0, drop_cnt 0, queue empty.
- Reset asserted mid-operation clears everything immediately (asynchronous). Outstanding responses that arrive after reset release are treated as unsolicited (proto_err); the system must quiesce memory before asserting reset.
- First request: first cycle after rst deasserts.
- Latency: request accepted in cycle N with a 1-cycle memory → response in N+1 → fetch_valid in N+2.
- Throughput: 1 instruction/cycle with a 1-cycle memory and no stall. This relies on the stall→pop→imem_req_valid combinational path.
- imem_req_valid, once asserted, stays high with a stable address until accepted, unless redirect_valid asserts.
- Redirect in cycle R: first new request issues in R+1 at redirect_pc; its data is visible in R+3 at the earliest.

## Structure
- risc16_pkg: word_t (logic [15:0]) and the fetch slot struct (alloc, filled, pc, instr) belong in the shared package.
- Sub-module fetch_queue: the 2-slot allocate/fill/pop queue with a flush input. if_fetch_unit keeps pc_q, drop_cnt, proto_err and the handshake logic.

## Test plan
- Reset with RESET_PC=0, ready=1, 1-cycle memory returning addr^16'hA5A5 → fetch_pc 0,1,2,… one per cycle from the 2nd cycle after reset release; instr matches.
- Queue full, stall=1 for 3 cycles → fetch_pc/instr stable; imem_req_valid=0; after release, sequence continues with no gap or duplicate.
- Two requests in flight (addr 5,6), redirect to 16'h0040 → both responses discarded; the next fetch_valid carries pc 16'h0040.
- imem_req_ready=0 for 4 cycles → imem_req_valid high with imem_req_addr constant; accepted on ready, no skipped address.
- RESET_PC=16'hFFFE → fetch_pc sequence FFFE, FFFF, 0000, 0001.
- imem_rsp_valid pulse with nothing outstanding → proto_err=1 and held; fetch_valid stays 0; cleared only by rst.
